rcb_frl_updown_counter: RTL and testbench
=========================================

# rcb_frl_updown_counter

Parametrised up/down counter for the Fast Radio Link receive path, used for tap-delay and bit-slip alignment tracking and training-pattern scoring. It generalises the legacy 7-bit count-to-128 counter with:
- configurable width, bounds and step;
- wrap or saturate mode;
- synchronous load;
- terminal-count and overflow/underflow flags;
- a hysteresis threshold flag.

All outputs are registered in the `clk` domain.

## Interface
- `WIDTH`, 7: counter width in bits.
- `MIN_VAL`, 0: lower bound, inclusive.
- `MAX_VAL`, 127: upper bound, inclusive; `MIN_VAL < MAX_VAL < 2^WIDTH`.
- `STEP`, 1: increment/decrement magnitude; `1 <= STEP <= MAX_VAL-MIN_VAL`.
- `RESET_VAL`, 0: value after reset and after `clr`; must lie in `[MIN_VAL, MAX_VAL]`.
- `SATURATE`, 0: 0 = wrap modulo range; 1 = clamp at bounds.
- `HI_THR`, 96 and `LO_THR`, 32: hysteresis set and clear thresholds; `LO_THR < HI_THR`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `clr` in 1: synchronous clear to `RESET_VAL`.
- `load` in 1: synchronous load of `load_value`.
- `load_value` in WIDTH: value to load.
- `en` in 1: count enable.
- `ud` in 1: direction, 1 = up, 0 = down.
- `err_clr` in 1: clears sticky error flags (macro build only).
- `count_value` out WIDTH: current count.
- `at_max` out 1: `count_value == MAX_VAL`.
- `at_min` out 1: `count_value == MIN_VAL`.
- `ovf` out 1: one-cycle pulse when an up step crossed `MAX_VAL`.
- `unf` out 1: one-cycle pulse when a down step crossed `MIN_VAL`.
- `hi_flag` out 1: hysteresis flag.
- `err_sticky` out 2: {sticky overflow, sticky underflow} (macro build only).

## Operation
- Command priority is `rst` > `clr` > `load` > `en`. With `en=0` and no `clr` or `load`, the count holds.
  - Unlike the legacy block, `en=0, ud=0` does NOT clear.
- Up step:
  - Compute `nxt = cnt + STEP` in WIDTH+1 bits.
  - If `nxt > MAX_VAL`:
    - Wrap mode: `cnt <= nxt - (MAX_VAL-MIN_VAL+1)`.
    - Saturate mode: `cnt <= MAX_VAL`.
    - In both modes, `ovf` pulses.
- Down step:
  - If `cnt < MIN_VAL + STEP`:
    - Wrap mode: `cnt <= cnt + (MAX_VAL-MIN_VAL+1) - STEP`.
    - Saturate mode: `cnt <= MIN_VAL`.
    - In both modes, `unf` pulses.
  - Arithmetic is done in WIDTH+1 bits so there is no native underflow.
- Saturate mode at a bound: stepping further into the bound leaves `cnt` unchanged and still pulses `ovf`/`unf`.
- Load: `load_value` is clamped to `[MIN_VAL, MAX_VAL]` and never sets `ovf` or `unf`.
- `at_max` and `at_min` are derived from the registered count, so they are valid in the same cycle as `count_value`.
- `hi_flag`:
  - Set when the next count is >= `HI_THR`.
  - Cleared when the next count is <= `LO_THR`.
  - Otherwise holds.
  - Evaluated after `clr` and `load` as well.
- Reset values: `count_value = RESET_VAL`; `at_min`/`at_max` reflect `RESET_VAL`; `ovf = unf = 0`; `hi_flag` is recomputed from `RESET_VAL` (0 for the defaults); `err_sticky = 0`.

## Timing
- Latency is 1 cycle: a command sampled at edge N is visible on `count_value` and all flags after edge N.
- `ovf` and `unf` are high for exactly the cycle following the causing edge. Back-to-back crossings produce back-to-back pulses.
- `clr` or `load` together with `en`: `en` is ignored that cycle, with no step and no pulse.
- `rst` asserted mid-operation forces reset values immediately (asynchronously). Counting resumes on the first edge after deassertion.
- Deassertion of `rst` is synchronised externally; this block has no internal reset synchroniser.

## Configuration
- `RCB_FRL_UDCNT_STICKY_ERR_EN` defined:
  - `err_sticky[1]` latches on any `ovf`; `err_sticky[0]` latches on any `unf`.
  - Both bits clear synchronously on `err_clr`. A new event in the same cycle as `err_clr` wins, so the bit stays 1.
  - Both bits clear on `rst`.
- Macro undefined: `err_sticky` and `err_clr` are absent from the port list, and no sticky logic is built.

## Test plan
- Defaults, wrap mode: reset, then 128 up steps → `count_value` goes 0..127 then 0. `ovf` pulses once, in the cycle `count_value` becomes 0. `at_max=1` while at 127.
- Defaults, down step from 0 → `count_value=127`, `unf` pulses once, `at_min` drops.
- `SATURATE=1`, `STEP=5`, `MAX_VAL=100`: load 98, then one up step → count 100 with `ovf` pulse. A further up step → count stays 100 with another `ovf` pulse.
- Hysteresis with defaults: step up to 96 → `hi_flag=1`. Down to 33 → `hi_flag` still 1. Down to 32 → `hi_flag=0`.
- Priority: `clr=1`, `load=1` (`load_value=50`) and `en=1` in the same cycle → count = `RESET_VAL` (0), no pulse. Next cycle `load=1`, `en=1` → count 50. Load of 200 with `MAX_VAL=127` → count 127, no `ovf`. Assert `rst` mid-count → count 0 asynchronously.
- Macro build: force an overflow → `err_sticky=2'b10`, held after the pulse. Assert `err_clr` → `2'b00`. Assert `err_clr` in the same cycle as an underflow → `2'b01`.

Source files
------------

// File: rtl/rcb_frl_updown_counter.sv
// rtl/rcb_frl_updown_counter.sv - bounded up/down counter with wrap/saturate, load, pulses and hysteresis flag
// Defining RCB_FRL_UDCNT_STICKY_ERR_EN adds err_clr/err_sticky sticky overflow/underflow flags.
module rcb_frl_updown_counter #(
   parameter int unsigned WIDTH     = 7,
   parameter int unsigned MIN_VAL   = 0,
   parameter int unsigned MAX_VAL   = 127,
   parameter int unsigned STEP      = 1,
   parameter int unsigned RESET_VAL = 0,
   parameter int unsigned SATURATE  = 0,
   parameter int unsigned HI_THR    = 96,
   parameter int unsigned LO_THR    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             en,
   input  logic             ud,
`ifdef RCB_FRL_UDCNT_STICKY_ERR_EN
   input  logic             err_clr,
`endif
   output logic [WIDTH-1:0] count_value,
   output logic             at_max,
   output logic             at_min,
   output logic             ovf,
   output logic             unf,
   output logic             hi_flag
`ifdef RCB_FRL_UDCNT_STICKY_ERR_EN
   ,
   output logic [1:0]       err_sticky
`endif
);

   // One extra bit of headroom keeps every step free of native wrap.
   localparam logic [WIDTH:0]   MIN_X   = (WIDTH+1)'(MIN_VAL);
   localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   RANGE_X = (WIDTH+1)'(MAX_VAL - MIN_VAL + 1);
   localparam logic [WIDTH:0]   HI_X    = (WIDTH+1)'(HI_THR);
   localparam logic [WIDTH:0]   LO_X    = (WIDTH+1)'(LO_THR);
   localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);
   localparam logic [WIDTH:0]   RST_X   = (WIDTH+1)'(RESET_VAL);
   localparam logic             RST_AT_MAX = (RESET_VAL == MAX_VAL);
   localparam logic             RST_AT_MIN = (RESET_VAL == MIN_VAL);
   localparam logic             RST_HI     = (RESET_VAL >= HI_THR);

   logic [WIDTH-1:0] count_q, count_d;
   logic             at_max_q, at_max_d;
   logic             at_min_q, at_min_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             hi_flag_q, hi_flag_d;

   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   load_ext;
   logic [WIDTH:0]   count_x;

   always_comb begin
      cnt_ext  = {1'b0, count_q};
      up_sum   = cnt_ext + STEP_X;
      load_ext = {1'b0, load_value};
      count_x  = cnt_ext;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;

      if (clr) begin
         count_x = RST_X;
      end else if (load) begin
         if (load_ext < MIN_X) begin
            count_x = MIN_X;
         end else if (load_ext > MAX_X) begin
            count_x = MAX_X;
         end else begin
            count_x = load_ext;
         end
      end else if (en) begin
         if (ud) begin
            if (up_sum > MAX_X) begin
               ovf_d   = 1'b1;
               count_x = (SATURATE != 0) ? MAX_X : (up_sum - RANGE_X);
            end else begin
               count_x = up_sum;
            end
         end else begin
            if (cnt_ext < (MIN_X + STEP_X)) begin
               unf_d   = 1'b1;
               count_x = (SATURATE != 0) ? MIN_X : (cnt_ext + (RANGE_X - STEP_X));
            end else begin
               count_x = cnt_ext - STEP_X;
            end
         end
      end

      count_d  = WIDTH'(count_x);
      at_max_d = (count_x == MAX_X);
      at_min_d = (count_x == MIN_X);

      // Between the thresholds the flag keeps its previous value.
      hi_flag_d = hi_flag_q;
      if (count_x >= HI_X) begin
         hi_flag_d = 1'b1;
      end else if (count_x <= LO_X) begin
         hi_flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= RST_W;
         at_max_q  <= RST_AT_MAX;
         at_min_q  <= RST_AT_MIN;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         hi_flag_q <= RST_HI;
      end else begin
         count_q   <= count_d;
         at_max_q  <= at_max_d;
         at_min_q  <= at_min_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         hi_flag_q <= hi_flag_d;
      end
   end

   assign count_value = count_q;
   assign at_max      = at_max_q;
   assign at_min      = at_min_q;
   assign ovf         = ovf_q;
   assign unf         = unf_q;
   assign hi_flag     = hi_flag_q;

`ifdef RCB_FRL_UDCNT_STICKY_ERR_EN
   logic [1:0] err_sticky_q, err_sticky_d;

   // A fresh event outranks err_clr in the same cycle.
   always_comb begin
      err_sticky_d = err_clr ? 2'b00 : err_sticky_q;
      err_sticky_d = err_sticky_d | {ovf_d, unf_d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sticky_q <= 2'b00;
      end else begin
         err_sticky_q <= err_sticky_d;
      end
   end

   assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_rcb_frl_updown_counter.sv
// tb/tb_rcb_frl_updown_counter.sv - self-checking bench for rcb_frl_updown_counter
// Also exercises the sticky error flags when RCB_FRL_UDCNT_STICKY_ERR_EN is defined.
module tb_rcb_frl_updown_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   always #5 clk = ~clk;

   logic       clr = 1'b0, load = 1'b0, en = 1'b0, ud = 1'b0;
   logic [6:0] lv = '0;
   logic [6:0] cnt;
   logic       at_max, at_min, ovf, unf, hi;

   logic       s_clr = 1'b0, s_load = 1'b0, s_en = 1'b0, s_ud = 1'b0;
   logic [6:0] s_lv = '0;
   logic [6:0] s_cnt;
   logic       s_at_max, s_at_min, s_ovf, s_unf, s_hi;

`ifdef RCB_FRL_UDCNT_STICKY_ERR_EN
   logic       err_clr = 1'b0;
   logic [1:0] err_sticky;
   logic       s_err_clr = 1'b0;
   logic [1:0] s_err_sticky;
`endif

   rcb_frl_updown_counter dut (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .load_value(lv),
      .en(en), .ud(ud),
`ifdef RCB_FRL_UDCNT_STICKY_ERR_EN
      .err_clr(err_clr),
`endif
      .count_value(cnt), .at_max(at_max), .at_min(at_min),
      .ovf(ovf), .unf(unf), .hi_flag(hi)
`ifdef RCB_FRL_UDCNT_STICKY_ERR_EN
      , .err_sticky(err_sticky)
`endif
   );

   rcb_frl_updown_counter #(.MAX_VAL(100), .STEP(5), .SATURATE(1)) dut_sat (
      .clk(clk), .rst(rst), .clr(s_clr), .load(s_load), .load_value(s_lv),
      .en(s_en), .ud(s_ud),
`ifdef RCB_FRL_UDCNT_STICKY_ERR_EN
      .err_clr(s_err_clr),
`endif
      .count_value(s_cnt), .at_max(s_at_max), .at_min(s_at_min),
      .ovf(s_ovf), .unf(s_unf), .hi_flag(s_hi)
`ifdef RCB_FRL_UDCNT_STICKY_ERR_EN
      , .err_sticky(s_err_sticky)
`endif
   );

   typedef struct packed {
      logic [6:0] cnt;
      logic       at_max;
      logic       at_min;
      logic       ovf;
      logic       unf;
      logic       hi;
   } obs_t;

   typedef struct {
      logic       c;
      logic       l;
      logic [6:0] v;
      logic       e;
      logic       u;
      int         exp_cnt;
      logic       exp_ovf;
      logic       exp_unf;
      logic       exp_hi;
   } vec_t;

   obs_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_cnt   = 0;
   logic m_hi    = 1'b0;

   function automatic obs_t mk(input int c, input logic o, input logic u, input logic h);
      obs_t r;
      r.cnt    = c[6:0];
      r.at_max = (c == 127);
      r.at_min = (c == 0);
      r.ovf    = o;
      r.unf    = u;
      r.hi     = h;
      return r;
   endfunction

   // Independent reference for the default (wrap, step 1, 0..127) instance.
   function automatic obs_t model(input logic c, input logic l, input int v, input logic e, input logic u);
      logic o = 1'b0, n = 1'b0;
      if (c) m_cnt = 0;
      else if (l) m_cnt = (v > 127) ? 127 : v;
      else if (e) begin
         if (u) begin
            m_cnt = m_cnt + 1;
            if (m_cnt > 127) begin m_cnt = m_cnt - 128; o = 1'b1; end
         end else begin
            if (m_cnt == 0) begin m_cnt = 127; n = 1'b1; end
            else m_cnt = m_cnt - 1;
         end
      end
      if (m_cnt >= 96) m_hi = 1'b1;
      else if (m_cnt <= 32) m_hi = 1'b0;
      return mk(m_cnt, o, n, m_hi);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step(input string name, input logic c, input logic l, input logic [6:0] v,
                       input logic e, input logic u, input obs_t expv);
      obs_t want;
      exp_q.push_back(expv);
      clr = c; load = l; lv = v; en = e; ud = u;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      check(name, 32'({cnt, at_max, at_min, ovf, unf, hi}), 32'(want));
      clr = 1'b0; load = 1'b0; en = 1'b0;
   endtask

   task automatic mstep(input string name, input logic e, input logic u);
      step(name, 1'b0, 1'b0, 7'd0, e, u, model(1'b0, 1'b0, 0, e, u));
   endtask

   task automatic s_step(input string name, input logic c, input logic l, input logic [6:0] v,
                         input logic e, input logic u, input logic [11:0] req);
      s_clr = c; s_load = l; s_lv = v; s_en = e; s_ud = u;
      @(posedge clk); #1;
      check(name, 32'({s_cnt, s_at_max, s_at_min, s_ovf, s_unf, s_hi}), 32'(req));
      s_clr = 1'b0; s_load = 1'b0; s_en = 1'b0;
   endtask

   vec_t vecs[14];
   int   ovf_seen;

   initial begin
      vecs[0]  = '{0, 0, 7'd0,   1, 0, 127, 0, 1, 1};
      vecs[1]  = '{0, 0, 7'd0,   0, 0, 127, 0, 0, 1};
      vecs[2]  = '{0, 0, 7'd0,   1, 1,   0, 1, 0, 0};
      vecs[3]  = '{1, 1, 7'd50,  1, 1,   0, 0, 0, 0};
      vecs[4]  = '{0, 1, 7'd50,  1, 1,  50, 0, 0, 0};
      vecs[5]  = '{0, 1, 7'd127, 0, 0, 127, 0, 0, 1};
      vecs[6]  = '{0, 0, 7'd0,   1, 1,   0, 1, 0, 0};
      vecs[7]  = '{0, 0, 7'd0,   1, 0, 127, 0, 1, 1};
      vecs[8]  = '{0, 1, 7'd33,  0, 0,  33, 0, 0, 1};
      vecs[9]  = '{0, 0, 7'd0,   1, 0,  32, 0, 0, 0};
      vecs[10] = '{0, 0, 7'd0,   1, 1,  33, 0, 0, 0};
      vecs[11] = '{0, 1, 7'd96,  0, 0,  96, 0, 0, 1};
      vecs[12] = '{0, 1, 7'd95,  0, 0,  95, 0, 0, 1};
      vecs[13] = '{0, 1, 7'd32,  1, 0,  32, 0, 0, 0};

      repeat (2) @(posedge clk);
      #1;
      check("reset_default", 32'({cnt, at_max, at_min, ovf, unf, hi}), 32'(mk(0, 0, 0, 0)));
      check("reset_sat", 32'({s_cnt, s_at_max, s_at_min, s_ovf, s_unf, s_hi}), 32'({7'd0, 5'b01000}));
`ifdef RCB_FRL_UDCNT_STICKY_ERR_EN
      check("reset_sticky", 32'(err_sticky), 32'd0);
`endif
      rst = 1'b0;

      foreach (vecs[i])
         step($sformatf("vec%0d", i), vecs[i].c, vecs[i].l, vecs[i].v, vecs[i].e, vecs[i].u,
              mk(vecs[i].exp_cnt, vecs[i].exp_ovf, vecs[i].exp_unf, vecs[i].exp_hi));

      // Full wrap sweep from a fresh reset.
      rst = 1'b1; #2; rst = 1'b0;
      m_cnt = 0; m_hi = 1'b0;
      ovf_seen = 0;
      for (int i = 0; i < 128; i++) begin
         mstep($sformatf("sweep%0d", i), 1'b1, 1'b1);
         if (ovf) ovf_seen++;
      end
      check("sweep_ovf_count", 32'(ovf_seen), 32'd1);

      // Hysteresis walk: up to 96, down to 33, then 32.
      for (int i = 0; i < 96; i++) mstep("hyst_up", 1'b1, 1'b1);
      check("hyst_set_96", 32'({cnt, hi}), 32'({7'd96, 1'b1}));
      for (int i = 0; i < 63; i++) mstep("hyst_dn", 1'b1, 1'b0);
      check("hyst_hold_33", 32'({cnt, hi}), 32'({7'd33, 1'b1}));
      mstep("hyst_dn32", 1'b1, 1'b0);
      check("hyst_clear_32", 32'({cnt, hi}), 32'({7'd32, 1'b0}));

      // Asynchronous reset between edges, then counting resumes.
      mstep("pre_rst", 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1 check("async_rst", 32'({cnt, at_max, at_min, ovf, unf, hi}), 32'(mk(0, 0, 0, 0)));
      @(posedge clk); #1;
      rst = 1'b0;
      m_cnt = 0; m_hi = 1'b0;
      mstep("post_rst", 1'b1, 1'b1);
      check("post_rst_value", 32'(cnt), 32'd1);

      // Saturating instance, step 5, bounds 0..100.
      s_step("sat_load98",  0, 1, 7'd98, 0, 0, {7'd98,  5'b00001});
      s_step("sat_up_clip", 0, 0, 7'd0,  1, 1, {7'd100, 5'b10101});
      s_step("sat_up_hold", 0, 0, 7'd0,  1, 1, {7'd100, 5'b10101});
      s_step("sat_idle",    0, 0, 7'd0,  0, 0, {7'd100, 5'b10001});
      s_step("sat_load3",   0, 1, 7'd3,  0, 0, {7'd3,   5'b00000});
      s_step("sat_dn_clip", 0, 0, 7'd0,  1, 0, {7'd0,   5'b01010});
      s_step("sat_dn_hold", 0, 0, 7'd0,  1, 0, {7'd0,   5'b01010});
      s_step("sat_load120", 0, 1, 7'd120, 1, 1, {7'd100, 5'b10001});

`ifdef RCB_FRL_UDCNT_STICKY_ERR_EN
      step("stk_load127", 0, 1, 7'd127, 0, 0, model(0, 1, 127, 0, 0));
      step("stk_ovf", 0, 0, 7'd0, 1, 1, model(0, 0, 0, 1, 1));
      check("sticky_ovf", 32'(err_sticky), 32'd2);
      mstep("stk_idle", 1'b0, 1'b0);
      check("sticky_held", 32'(err_sticky), 32'd2);
      err_clr = 1'b1;
      mstep("stk_clr", 1'b0, 1'b0);
      check("sticky_cleared", 32'(err_sticky), 32'd0);
      mstep("stk_clr_unf", 1'b1, 1'b0);
      err_clr = 1'b0;
      check("sticky_clr_vs_unf", 32'(err_sticky), 32'd1);
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
